// File: rtl/mac_result_collector.sv
`default_nettype none
// ============================================================================
//  Module   : mac_result_collector
//  Purpose  : Counts MAC products, queues each finished dot product with its
//             overflow flag in a small FIFO, then pulses acc_clr to clear MAC.
//  Revision : 1.0  initial release
// ============================================================================
module mac_result_collector #(
  parameter int VEC_LEN    = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] mac_f,
  input  logic        mac_valid_out,
  input  logic        mac_overflow,
  output logic        acc_clr,
  output logic        ready_vec,
  output logic [15:0] res_data,
  output logic        res_ovf,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        proto_err
);

  localparam int c_cnt_w = $clog2(VEC_LEN + 1);
  localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_lvl_w = $clog2(FIFO_DEPTH + 1);

  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(VEC_LEN - 1);
  localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(FIFO_DEPTH - 1);
  localparam logic [c_lvl_w-1:0] c_depth    = c_lvl_w'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 w_push;
  logic                 w_clear;

  logic [15:0]          r_mem_data [FIFO_DEPTH];
  logic                 r_mem_ovf  [FIFO_DEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_lvl_w-1:0]   r_level;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_wr;
  logic                 r_proto_err;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_push       = 1'b0;
    w_clear      = 1'b0;
    case (r_state)
      ST_ACCUM: begin
        if (mac_valid_out && (r_cnt == c_cnt_last)) begin
          w_push       = 1'b1;
          w_state_next = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        w_clear      = 1'b1;
        w_state_next = ST_ACCUM;
      end
      default: w_state_next = ST_ACCUM;
    endcase
  end

  // MAC is also held clear for as long as this block is in reset.
  assign acc_clr = reset | w_clear;

  // ------------------------------------------------------ product counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if ((r_state == ST_ACCUM) && mac_valid_out) begin
      if (r_cnt == c_cnt_last) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end
    end
  end

  // ---------------------------------------------------------- result FIFO
  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == c_depth);
  assign w_pop   = res_ready && !w_empty;
  // A push into a full FIFO only lands when the head leaves on the same edge.
  assign w_wr    = w_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem_data[r_wr_ptr] <= mac_f;
      r_mem_ovf[r_wr_ptr]  <= mac_overflow;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + c_ptr_w'(1);
      end
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + c_lvl_w'(1);
        2'b01:   r_level <= r_level - c_lvl_w'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign res_valid = !w_empty;
  assign res_data  = w_empty ? 16'h0000 : r_mem_data[r_rd_ptr];
  assign res_ovf   = w_empty ? 1'b0 : r_mem_ovf[r_rd_ptr];

  assign ready_vec = (r_state == ST_ACCUM) && (r_cnt == '0) && (r_level < c_depth);

  // --------------------------------------------------- protocol violation
  always_ff @(posedge clk) begin
    if (reset) begin
      r_proto_err <= 1'b0;
    end else if ((r_state == ST_CLEAR) && mac_valid_out) begin
      r_proto_err <= 1'b1;
    end
  end

  assign proto_err = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_mac_result_collector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mac_result_collector
//  Purpose  : Bench for mac_result_collector with a behavioural signed 8x8 MAC
//             upstream and a scoreboard queue of expected dot products.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mac_result_collector;

  logic               clk;
  logic               reset;
  logic signed [15:0] mac_f;
  logic               mac_vo;
  logic               force_vo;
  logic               mac_valid_out;
  logic               mac_overflow;
  logic               acc_clr;
  logic               ready_vec;
  logic [15:0]        res_data;
  logic               res_ovf;
  logic               res_valid;
  logic               res_ready;
  logic               proto_err;

  logic               valid_in;
  logic signed [7:0]  op_a;
  logic signed [7:0]  op_b;
  logic signed [15:0] w_prod;
  int                 w_sum;

  logic [16:0]        sb_q[$];
  int                 n_vec;
  int                 n_err;

  mac_result_collector #(.VEC_LEN(4), .FIFO_DEPTH(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .mac_f        (mac_f),
    .mac_valid_out(mac_valid_out),
    .mac_overflow (mac_overflow),
    .acc_clr      (acc_clr),
    .ready_vec    (ready_vec),
    .res_data     (res_data),
    .res_ovf      (res_ovf),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .proto_err    (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream MAC: f, valid_out and sticky overflow all update on one edge.
  assign mac_valid_out = mac_vo | force_vo;
  always_comb begin
    w_prod = 16'(op_a * op_b);
    w_sum  = int'(mac_f) + int'(w_prod);
  end

  always @(posedge clk) begin
    if (acc_clr) begin
      mac_f        <= '0;
      mac_vo       <= 1'b0;
      mac_overflow <= 1'b0;
    end else begin
      mac_vo <= valid_in;
      if (valid_in) begin
        mac_f <= w_sum[15:0];
        if (w_sum > 32767 || w_sum < -32768) mac_overflow <= 1'b1;
      end
    end
  end

  // Scoreboard: every accepted FIFO head is checked against the oldest expectation.
  always @(negedge clk) begin
    if (!reset && res_valid && res_ready) begin
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got data=%0d ovf=%b, want no result", $signed(res_data), res_ovf);
      end else begin
        logic [16:0] e;
        e = sb_q.pop_front();
        if ({res_ovf, res_data} !== e) begin
          n_err++;
          $display("FAIL sb_result: got data=%0d ovf=%b, want data=%0d ovf=%b",
                   $signed(res_data), res_ovf, $signed(e[15:0]), e[16]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [16:0] dot_model(input logic signed [7:0] a[4],
                                            input logic signed [7:0] b[4]);
    logic signed [15:0] acc;
    logic               ov;
    int                 s;
    acc = '0;
    ov  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s = int'(acc) + int'(a[i]) * int'(b[i]);
      if (s > 32767 || s < -32768) ov = 1'b1;
      acc = s[15:0];
    end
    return {ov, acc};
  endfunction

  // Waits for ready_vec, then issues four beats; returns just after the
  // edge on which the MAC absorbs the last beat.
  task automatic issue_vector(input logic signed [7:0] a[4], input logic signed [7:0] b[4],
                              input bit bubbles, output logic [16:0] expv);
    int t;
    t = 0;
    expv = dot_model(a, b);
    while (ready_vec !== 1'b1 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    n_vec++;
    if (ready_vec !== 1'b1) begin
      n_err++;
      $display("FAIL ready_vec_wait: got %b, want 1 within 200 cycles", ready_vec);
      return;
    end
    sb_q.push_back(expv);
    for (int i = 0; i < 4; i++) begin
      valid_in = 1'b1;
      op_a     = a[i];
      op_b     = b[i];
      @(posedge clk); #1;
      valid_in = 1'b0;
      if (bubbles && i < 3) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (acc_clr !== 1'b1) begin n_err++; $display("FAIL rst_acc_clr: got %b, want 1", acc_clr); end
    @(posedge clk); #1;
    n_vec++;
    if ({res_valid, ready_vec, proto_err, res_data, res_ovf} !== {1'b0, 1'b1, 1'b0, 16'h0, 1'b0}) begin
      n_err++;
      $display("FAIL rst_state: got valid=%b ready=%b perr=%b data=%h ovf=%b, want 0 1 0 0000 0",
               res_valid, ready_vec, proto_err, res_data, res_ovf);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (acc_clr !== 1'b0) begin n_err++; $display("FAIL rst_acc_clr_after: got %b, want 0", acc_clr); end
  endtask

  task automatic test_basic;
    logic [16:0] e;
    issue_vector('{8'sd2, 8'sd3, 8'sd100, 8'sd50}, '{8'sd2, -8'sd3, 8'sd2, 8'sd15}, 1'b0, e);
    n_vec++;
    if (e !== {1'b0, 16'd945}) begin n_err++; $display("FAIL basic_model: got %h, want 003b1", e); end
    n_vec++;
    if ({res_valid, acc_clr} !== 2'b00) begin
      n_err++; $display("FAIL basic_early: got valid=%b clr=%b, want 0 0", res_valid, acc_clr);
    end
    @(posedge clk); #1;
    n_vec++;
    if ({res_valid, acc_clr, res_data, res_ovf} !== {1'b1, 1'b1, 16'd945, 1'b0}) begin
      n_err++;
      $display("FAIL basic_push: got valid=%b clr=%b data=%0d ovf=%b, want 1 1 945 0",
               res_valid, acc_clr, $signed(res_data), res_ovf);
    end
    @(posedge clk); #1;
    n_vec++;
    if ({acc_clr, ready_vec, mac_f} !== {1'b0, 1'b1, 16'h0}) begin
      n_err++;
      $display("FAIL basic_clear: got clr=%b ready=%b f=%0d, want 0 1 0", acc_clr, ready_vec, mac_f);
    end
  endtask

  task automatic test_overflow;
    logic [16:0] e;
    issue_vector('{8'sd125, 8'sd125, 8'sd125, 8'sd125}, '{8'sd100, 8'sd100, 8'sd100, 8'sd100}, 1'b0, e);
    @(posedge clk); #1;
    n_vec++;
    if ({res_valid, res_data, res_ovf} !== {1'b1, 16'hC350, 1'b1}) begin
      n_err++;
      $display("FAIL ovf_push: got valid=%b data=%0d ovf=%b, want 1 -15536 1",
               res_valid, $signed(res_data), res_ovf);
    end
    issue_vector('{8'sd2, 8'sd2, 8'sd2, 8'sd2}, '{8'sd2, 8'sd2, 8'sd2, 8'sd2}, 1'b0, e);
    @(posedge clk); #1;
    n_vec++;
    if ({res_valid, res_data, res_ovf} !== {1'b1, 16'd16, 1'b0}) begin
      n_err++;
      $display("FAIL ovf_next: got valid=%b data=%0d ovf=%b, want 1 16 0",
               res_valid, $signed(res_data), res_ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fifo_full;
    logic [16:0] e;
    int          t;
    res_ready = 1'b0;
    issue_vector('{8'sd1, 8'sd1, 8'sd1, 8'sd1}, '{8'sd1, 8'sd1, 8'sd1, 8'sd1}, 1'b0, e);
    issue_vector('{-8'sd3, -8'sd3, -8'sd3, -8'sd3}, '{8'sd5, 8'sd5, 8'sd5, 8'sd5}, 1'b0, e);
    repeat (5) @(posedge clk);
    #1;
    n_vec++;
    if ({ready_vec, res_valid, res_data} !== {1'b0, 1'b1, 16'd4} || sb_q.size() != 2) begin
      n_err++;
      $display("FAIL full_block: got ready=%b valid=%b head=%0d pending=%0d, want 0 1 4 2",
               ready_vec, res_valid, $signed(res_data), sb_q.size());
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    n_vec++;
    if ({ready_vec, res_data} !== {1'b1, 16'hFFC4}) begin
      n_err++;
      $display("FAIL full_pop: got ready=%b head=%0d, want 1 -60", ready_vec, $signed(res_data));
    end
    issue_vector('{8'sd127, 8'sd127, 8'sd127, 8'sd127}, '{8'sd127, 8'sd127, 8'sd127, 8'sd127}, 1'b0, e);
    repeat (3) @(posedge clk);
    #1;
    res_ready = 1'b1;
    t = 0;
    while (res_valid === 1'b1 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    n_vec++;
    if (res_valid !== 1'b0 || sb_q.size() != 0) begin
      n_err++;
      $display("FAIL full_drain: got valid=%b pending=%0d, want 0 0", res_valid, sb_q.size());
    end
  endtask

  task automatic test_bubbles;
    logic [16:0] e;
    issue_vector('{-8'sd7, 8'sd9, 8'sd11, -8'sd128}, '{8'sd13, -8'sd4, 8'sd6, 8'sd3}, 1'b1, e);
    @(posedge clk); #1;
    n_vec++;
    if ({res_valid, res_ovf, res_data} !== {1'b1, e}) begin
      n_err++;
      $display("FAIL bubble_push: got valid=%b data=%0d ovf=%b, want 1 %0d %b",
               res_valid, $signed(res_data), res_ovf, $signed(e[15:0]), e[16]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_and_proto;
    logic [16:0] e;
    valid_in = 1'b1; op_a = 8'sd9; op_b = 8'sd9;
    @(posedge clk); #1;
    op_a = 8'sd4; op_b = -8'sd6;
    @(posedge clk); #1;
    valid_in = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({res_valid, ready_vec, mac_f} !== {1'b0, 1'b1, 16'h0}) begin
      n_err++;
      $display("FAIL midrst: got valid=%b ready=%b f=%0d, want 0 1 0", res_valid, ready_vec, mac_f);
    end
    issue_vector('{8'sd10, 8'sd20, 8'sd30, 8'sd40}, '{8'sd1, 8'sd2, 8'sd3, 8'sd4}, 1'b0, e);
    @(posedge clk); #1;
    n_vec++;
    if ({res_valid, res_data, res_ovf} !== {1'b1, 16'd300, 1'b0}) begin
      n_err++;
      $display("FAIL midrst_next: got valid=%b data=%0d ovf=%b, want 1 300 0",
               res_valid, $signed(res_data), res_ovf);
    end
    force_vo = 1'b1;
    @(posedge clk); #1;
    force_vo = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({proto_err, res_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL proto_set: got perr=%b valid=%b, want 1 0", proto_err, res_valid);
    end
    issue_vector('{8'sd1, 8'sd1, 8'sd1, 8'sd1}, '{8'sd3, 8'sd3, 8'sd3, 8'sd3}, 1'b0, e);
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (proto_err !== 1'b1) begin n_err++; $display("FAIL proto_sticky: got %b, want 1", proto_err); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_vec++;
    if (proto_err !== 1'b0) begin n_err++; $display("FAIL proto_clear: got %b, want 0", proto_err); end
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    reset     = 1'b1;
    valid_in  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    force_vo  = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    test_reset;
    test_basic;
    test_overflow;
    test_fifo_full;
    res_ready = 1'b1;
    test_bubbles;
    test_reset_mid_and_proto;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: got %0d pending results, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
